// File: rtl/countdown_timer_minsec.sv
// -----------------------------------------------------------------------------
// countdown_timer_minsec
//   MM:SS kitchen countdown timer. Buttons set minutes/seconds and start,
//   pause or clear the count. The block counts down once per second and
//   raises an alarm at 00:00. It drives BCD digits to the 4-digit FND
//   controller. Button debounce, edge detection and the 1 s prescaler are all
//   internal.
//
// Parameters
//   CLK_HZ          clk cycles per one-second tick
//   DEBOUNCE_CYCLES button sampling period in clk cycles
//   ALARM_SEC       seconds the alarm stays up before returning to IDLE
//
// Ports
//   clk      in   system clock
//   reset_p  in   asynchronous reset, active-high
//   btn[3:0] in   raw buttons: [0] start/pause, [1] sec+, [2] min+, [3] clear
//   value    out  BCD {min10, min1, sec10, sec1}
//   alarm    out  high while in ALARM (blinking when ALARM_BLINK_EN)
//   led_bar  out  [0]=RUN, [1]=PAUSE, [2]=alarm, [7:3]=0
//
// Build option
//   ALARM_BLINK_EN  when defined, alarm and led_bar[2] toggle every CLK_HZ/2
//                   cycles in ALARM, starting high. Otherwise they are steady
//                   high for the whole ALARM period.
// -----------------------------------------------------------------------------
module countdown_timer_minsec #(
  parameter int CLK_HZ          = 100_000_000,
  parameter int DEBOUNCE_CYCLES = 131_072,
  parameter int ALARM_SEC       = 10
) (
  input  logic        clk,
  input  logic        reset_p,
  input  logic [3:0]  btn,
  output logic [15:0] value,
  output logic        alarm,
  output logic [7:0]  led_bar
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int AW = (ALARM_SEC > 1) ? $clog2(ALARM_SEC) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_HZ - 1);
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW-1:0] A_LAST   = AW'(ALARM_SEC - 1);
`ifdef ALARM_BLINK_EN
  localparam logic [PW-1:0] PRE_HALF = PW'(CLK_HZ / 2);
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_ALARM} state_t;

  // One decoded command per cycle after priority resolution.
  typedef struct packed {
    logic clr;
    logic start;
    logic min_inc;
    logic sec_inc;
  } cmd_t;

  // ---------------------------------------------------------------------------
  // BCD helpers for a 00..59 field
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] bcd60_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      if (v[7:4] == 4'd5) r = 8'h00;
      else                r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  function automatic logic [7:0] bcd60_dec(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd0) begin
      if (v[7:4] == 4'd0) r = 8'h59;
      else                r = {v[7:4] - 4'd1, 4'd9};
    end else begin
      r = {v[7:4], v[3:0] - 4'd1};
    end
    return r;
  endfunction

  // One-second decrement with borrow from minutes (never called at 00:00).
  function automatic logic [15:0] mmss_dec(input logic [15:0] v);
    logic [7:0] m, s;
    s = bcd60_dec(v[7:0]);
    m = (v[7:0] == 8'h00) ? bcd60_dec(v[15:8]) : v[15:8];
    return {m, s};
  endfunction

  // ---------------------------------------------------------------------------
  // Debounce: two-flop synchroniser, then a slow sampler. Only a 0->1 change
  // of the sampled bit produces a single-cycle pulse, so bounce shorter than
  // the sampling period is invisible.
  // ---------------------------------------------------------------------------
  logic [3:0]    sync1, sync2, samp, samp_d;
  logic [DW-1:0] dcnt;
  logic [3:0]    pulse;

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      sync1  <= '0;
      sync2  <= '0;
      samp   <= '0;
      samp_d <= '0;
      dcnt   <= '0;
    end else begin
      sync1  <= btn;
      sync2  <= sync1;
      samp_d <= samp;
      if (dcnt == DB_LAST) begin
        dcnt <= '0;
        samp <= sync2;
      end else begin
        dcnt <= dcnt + DW'(1);
      end
    end
  end

  assign pulse = samp & ~samp_d;

  // clear > start/pause > min+ > sec+; lower-priority pulses are dropped.
  cmd_t cmd;
  logic any_btn;

  always_comb begin
    cmd = '0;
    if      (pulse[3]) cmd.clr     = 1'b1;
    else if (pulse[0]) cmd.start   = 1'b1;
    else if (pulse[2]) cmd.min_inc = 1'b1;
    else if (pulse[1]) cmd.sec_inc = 1'b1;
  end

  assign any_btn = |pulse;

  // ---------------------------------------------------------------------------
  // Timer FSM and datapath
  // ---------------------------------------------------------------------------
  state_t        state, state_n;
  logic [15:0]   value_n;
  logic [PW-1:0] pre, pre_n;
  logic [AW-1:0] acnt, acnt_n;
  logic          tick;
  logic          alarm_n;
  logic [7:0]    led_n;

  assign tick = (pre == PRE_LAST);

  // State register, datapath and registered outputs.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state   <= S_IDLE;
      value   <= '0;
      pre     <= '0;
      acnt    <= '0;
      alarm   <= 1'b0;
      led_bar <= '0;
    end else begin
      state   <= state_n;
      value   <= value_n;
      pre     <= pre_n;
      acnt    <= acnt_n;
      alarm   <= alarm_n;
      led_bar <= led_n;
    end
  end

  // Next state. The prescaler defaults to 0, so every entry into RUN/ALARM
  // and every stay in IDLE/PAUSE leaves it cleared; it advances only while
  // counting in RUN or ALARM.
  always_comb begin
    state_n = state;
    value_n = value;
    pre_n   = '0;
    acnt_n  = acnt;
    if (cmd.clr) begin
      state_n = S_IDLE;
      value_n = '0;
    end else begin
      case (state)
        S_IDLE, S_PAUSE: begin
          if (cmd.start) begin
            // Zero value: IDLE stays put, PAUSE falls back to IDLE.
            state_n = (value != 16'h0000) ? S_RUN : S_IDLE;
          end else if (cmd.min_inc) begin
            value_n[15:8] = bcd60_inc(value[15:8]);
          end else if (cmd.sec_inc) begin
            value_n[7:0] = bcd60_inc(value[7:0]);
          end
        end
        S_RUN: begin
          // Start wins over a coincident tick: pause without decrementing.
          if (cmd.start) begin
            state_n = S_PAUSE;
          end else if (tick) begin
            value_n = mmss_dec(value);
            if (value == 16'h0001) begin
              state_n = S_ALARM;
              acnt_n  = '0;
            end
          end else begin
            pre_n = pre + PW'(1);
          end
        end
        S_ALARM: begin
          value_n = '0;
          if (any_btn) begin
            state_n = S_IDLE;
          end else if (tick) begin
            if (acnt == A_LAST) state_n = S_IDLE;
            else                acnt_n  = acnt + AW'(1);
          end else begin
            pre_n = pre + PW'(1);
          end
        end
        default: begin
          state_n = S_IDLE;
          value_n = '0;
        end
      endcase
    end
  end

  // Outputs derived from the next state so the registered copies line up
  // with state/value on the same edge.
  always_comb begin
`ifdef ALARM_BLINK_EN
    alarm_n = (state_n == S_ALARM) && (pre_n < PRE_HALF);
`else
    alarm_n = (state_n == S_ALARM);
`endif
    led_n = {5'b0, alarm_n, state_n == S_PAUSE, state_n == S_RUN};
  end

endmodule

// File: tb/tb_countdown_timer_minsec.sv
module tb_countdown_timer_minsec;

  localparam int HZ   = 100;
  localparam int DB   = 4;
  localparam int ASEC = 10;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_ALARM = 3;

  logic        clk = 1'b0;
  logic        reset_p = 1'b0;
  logic [3:0]  btn = 4'b0;
  logic [15:0] value;
  logic        alarm;
  logic [7:0]  led_bar;

  always #5 clk = ~clk;

  countdown_timer_minsec #(
    .CLK_HZ(HZ),
    .DEBOUNCE_CYCLES(DB),
    .ALARM_SEC(ASEC)
  ) dut (
    .clk(clk),
    .reset_p(reset_p),
    .btn(btn),
    .value(value),
    .alarm(alarm),
    .led_bar(led_bar)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: time kept as total seconds, phase as cycles since the
  // current RUN/ALARM interval began.
  int         m_st, m_secs, m_cyc, e;
  logic [3:0] h1, h2, m_samp, m_pulse;

  function automatic logic [15:0] to_bcd(input int s);
    int m, ss;
    m  = s / 60;
    ss = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic logic exp_alarm();
    if (m_st != M_ALARM) return 1'b0;
`ifdef ALARM_BLINK_EN
    return ((m_cyc / (HZ / 2)) % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [7:0] exp_led();
    return {5'b0, exp_alarm(), m_st == M_PAUSE, m_st == M_RUN};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_st = M_IDLE; m_secs = 0; m_cyc = 0; e = 0;
    h1 = 4'b0; h2 = 4'b0; m_samp = 4'b0; m_pulse = 4'b0;
  endtask

  // Effect of one clock edge: act on the pulse seen in the preceding cycle,
  // then derive the pulse for the next cycle from the sampled buttons.
  task automatic model_edge();
    logic clr, st, mn, sc;
    clr = m_pulse[3];
    st  = !clr && m_pulse[0];
    mn  = !clr && !m_pulse[0] && m_pulse[2];
    sc  = !clr && !m_pulse[0] && !m_pulse[2] && m_pulse[1];
    if (clr) begin
      m_st = M_IDLE; m_secs = 0;
    end else begin
      case (m_st)
        M_IDLE, M_PAUSE: begin
          if (st) begin
            if (m_secs != 0) begin m_st = M_RUN; m_cyc = 0; end
            else m_st = M_IDLE;
          end else if (mn) m_secs = ((m_secs / 60 + 1) % 60) * 60 + m_secs % 60;
          else if (sc)     m_secs = (m_secs / 60) * 60 + (m_secs % 60 + 1) % 60;
        end
        M_RUN: begin
          if (st) m_st = M_PAUSE;
          else begin
            m_cyc++;
            if (m_cyc == HZ) begin
              m_cyc = 0;
              m_secs--;
              if (m_secs == 0) m_st = M_ALARM;
            end
          end
        end
        default: begin
          if (m_pulse != 4'b0) m_st = M_IDLE;
          else begin
            m_cyc++;
            if (m_cyc == ASEC * HZ) m_st = M_IDLE;
          end
        end
      endcase
    end
    // Buttons pass two sync flops, then are sampled every DB-th edge.
    if (e % DB == DB - 1) begin
      m_pulse = h2 & ~m_samp;
      m_samp  = h2;
    end else begin
      m_pulse = 4'b0;
    end
    h2 = h1;
    h1 = btn;
    e++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("cycle", {7'b0, value, alarm, led_bar},
                 {7'b0, to_bcd(m_secs), exp_alarm(), exp_led()});
  endtask

  task automatic press(input logic [3:0] b);
    btn = b;
    repeat (3 * DB) step();
    btn = 4'b0;
    repeat (3 * DB) step();
  endtask

  // Step until the model reaches st (bounded), then confirm the DUT agrees.
  task automatic wait_state(input int st, input int budget, input string tag);
    int n;
    n = 0;
    while (m_st != st && n < budget) begin
      step();
      n++;
    end
    chk(tag, {30'b0, led_bar[1:0]}, (st == M_RUN) ? 32'd1 : (st == M_PAUSE) ? 32'd2 : 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic       prev;
    int         tog;
    logic [3:0] b;

    // Reset state
    #1 reset_p = 1'b1;
    #1;
    chk("rst_value", {16'b0, value}, 32'h0000);
    chk("rst_alarm", {31'b0, alarm}, 32'd0);
    chk("rst_led",   {24'b0, led_bar}, 32'd0);
    @(negedge clk); @(negedge clk);
    reset_p = 1'b0;
    model_reset();

    // Wrapping edits without carry
    repeat (61) press(4'b0010);
    chk("sec61", {16'b0, value}, 32'h0001);
    repeat (60) press(4'b0100);
    chk("min60", {16'b0, value}, 32'h0001);

    // 01:00 countdown to alarm
    press(4'b1000);
    press(4'b0100);
    chk("set_0100", {16'b0, value}, 32'h0100);
    btn = 4'b0001;
    wait_state(M_RUN, 40, "start_run");
    btn = 4'b0;
    repeat (HZ - 1) step();
    chk("pre_tick", {16'b0, value}, 32'h0100);
    step();
    chk("first_dec", {16'b0, value}, 32'h0059);
    repeat (5900) step();
    chk("zero", {16'b0, value}, 32'h0000);
    chk("alarm_on", {31'b0, alarm}, 32'd1);
    chk("led_alarm", {31'b0, led_bar[2]}, 32'd1);

    // Alarm timeout (and blinking when enabled)
    prev = alarm;
    tog  = 0;
    for (int i = 0; i < ASEC * HZ - 1; i++) begin
      step();
      if (alarm !== prev) tog++;
      prev = alarm;
    end
`ifdef ALARM_BLINK_EN
    chk("blink_toggles", tog, 32'd19);
`else
    chk("blink_toggles", tog, 32'd0);
`endif
    step();
    chk("alarm_timeout", {31'b0, alarm}, 32'd0);
    chk("timeout_led", {24'b0, led_bar}, 32'd0);

    // Pause / resume at 00:30
    press(4'b1000);
    repeat (30) press(4'b0010);
    chk("set30", {16'b0, value}, 32'h0030);
    btn = 4'b0001;
    wait_state(M_RUN, 40, "run30");
    btn = 4'b0;
    repeat (20) step();
    btn = 4'b0001;
    wait_state(M_PAUSE, 40, "pause30");
    btn = 4'b0;
    chk("pause_val", {16'b0, value}, 32'h0030);
    repeat (500) step();
    chk("pause_hold", {16'b0, value}, 32'h0030);
    btn = 4'b0001;
    wait_state(M_RUN, 40, "resume");
    btn = 4'b0;
    repeat (HZ - 1) step();
    chk("resume_pre", {16'b0, value}, 32'h0030);
    step();
    chk("resume_dec", {16'b0, value}, 32'h0029);

    // PAUSE at 00:00 (via sec+ wrap), start returns to IDLE
    btn = 4'b0001;
    wait_state(M_PAUSE, 40, "pause29");
    btn = 4'b0;
    repeat (31) press(4'b0010);
    chk("pause_zero", {16'b0, value}, 32'h0000);
    btn = 4'b0001;
    wait_state(M_IDLE, 40, "pause_start_zero");
    btn = 4'b0;
    repeat (20) step();

    // Start at 00:00 in IDLE is ignored
    press(4'b0001);
    chk("start_zero_led", {24'b0, led_bar}, 32'd0);

    // Same-cycle pulses
    repeat (5) press(4'b0010);
    btn = 4'b0011;
    wait_state(M_RUN, 40, "start_sec");
    chk("prio_val", {16'b0, value}, 32'h0005);
    btn = 4'b0;
    repeat (20) step();
    btn = 4'b1001;
    wait_state(M_IDLE, 40, "clr_start");
    chk("clr_val", {16'b0, value}, 32'h0000);
    btn = 4'b0;
    repeat (20) step();

    // Asynchronous reset in the middle of RUN at 01:23
    press(4'b0100);
    repeat (23) press(4'b0010);
    btn = 4'b0001;
    wait_state(M_RUN, 40, "run123");
    btn = 4'b0;
    repeat (37) step();
    chk("pre_rst", {16'b0, value}, 32'h0123);
    #2 reset_p = 1'b1;
    #1;
    chk("arst_value", {16'b0, value}, 32'h0000);
    chk("arst_alarm", {31'b0, alarm}, 32'd0);
    chk("arst_led", {24'b0, led_bar}, 32'd0);
    @(negedge clk); @(negedge clk);
    reset_p = 1'b0;
    model_reset();

    // Random button activity, including short glitches
    for (int i = 0; i < 150; i++) begin
      b = 4'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) b[3] = 1'b1;
      btn = b;
      repeat ($urandom_range(1, 24)) step();
      btn = 4'b0;
      repeat ($urandom_range(0, 200)) step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/countdown_timer_minsec.md
Name: countdown_timer_minsec

Overview:
MM:SS countdown (kitchen) timer, the down-counting counterpart of the team's stopwatch. The user sets minutes and seconds with buttons, then starts, pauses or clears. The block counts down once per second, raises an alarm at 00:00 and drives the 4-digit FND controller with BCD digits. It is self-contained: button debounce, edge detection and the 1 s prescaler are all internal.

Parameters:
CLK_HZ, 100_000_000, clk cycles per second tick (bench uses small values)
DEBOUNCE_CYCLES, 131_072, button sampling period in clk cycles
ALARM_SEC, 10, seconds the alarm stays up before auto-return to IDLE

Ports:
clk  input  1  system clock
reset_p  input  1  asynchronous reset, active-high
btn  input  4  raw buttons: [0] start/pause, [1] sec+, [2] min+, [3] clear
value  output  16  BCD {min10, min1, sec10, sec1} to FND controller
alarm  output  1  high in ALARM state
led_bar  output  8  [0]=RUN, [1]=PAUSE, [2]=alarm, [7:3]=0

Behaviour:
- Reset (async, active-high): state=IDLE, value=16'h0000, alarm=0, led_bar=0, prescaler=0, debounce registers=0.
- Debounce: each btn bit is sampled into a register once every DEBOUNCE_CYCLES clocks. A 0->1 change of the sampled bit gives a one-clk pulse. Guaranteed detection needs the button stable for ≥2*DEBOUNCE_CYCLES.
- Pulse priority when several pulses land in one cycle: clear > start/pause > min+ > sec+. Only the highest-priority pulse acts; the others are dropped.
- States: IDLE, RUN, PAUSE, ALARM.
- IDLE:
  - sec+ increments seconds 00..59, wrapping 59->00 with no carry into minutes.
  - min+ increments minutes, wrapping 59->00.
  - start with value≠0 -> RUN; prescaler cleared.
  - start with value=0 is ignored.
- RUN:
  - Prescaler counts 0..CLK_HZ-1. At terminal count the tick decrements value by 1 s with BCD borrow (e.g. 10:00 -> 09:59).
  - The first decrement comes exactly CLK_HZ cycles after the start pulse.
  - start -> PAUSE; value held.
  - sec+/min+ ignored.
  - A tick taking value 00:01 -> 00:00 also moves the state to ALARM at the same edge.
- PAUSE:
  - value held; sec+/min+ edit as in IDLE.
  - start with value≠0 -> RUN, prescaler cleared (a full second to the next decrement).
  - start with value=0 -> IDLE.
- ALARM:
  - alarm=1; value=0000.
  - Any button pulse -> IDLE.
  - Otherwise auto -> IDLE after ALARM_SEC seconds, counted with the prescaler, which is cleared on entry.
- clear from any state -> IDLE with value=0000 on the next edge; prescaler cleared.
- Outputs are registered; a button-pulse effect appears on value/led_bar one clk after the pulse.
- Prescaler runs only in RUN and ALARM and holds 0 otherwise.
- Digits are always valid BCD (0-9, tens 0-5).

Optional Feature:
ALARM_BLINK_EN
- Defined: in ALARM, alarm and led_bar[2] toggle every CLK_HZ/2 cycles, starting high on entry.
- Undefined: alarm and led_bar[2] are steady high throughout ALARM.
- Timeout and all other behaviour are identical either way.

Test Plan:
- CLK_HZ=100, DEBOUNCE_CYCLES=4 -> reset mid-RUN with value 01:23 -> value=0000, led_bar=0, alarm=0 immediately (async).
- IDLE, press sec+ 61 times -> value=0001; press min+ 60 times -> value=0001.
- Set 01:00, start -> 100 clks later value=0059; after a further 5900 clks value=0000, alarm=1, led_bar[2]=1.
- RUN at 00:30, start -> PAUSE; hold 500 clks -> value stays 0030; start -> next decrement exactly 100 clks later to 0029.
- ALARM, no buttons, ALARM_SEC=10 -> IDLE after 1000 clks, alarm=0. With ALARM_BLINK_EN, alarm toggles every 50 clks during that window.
- start and sec+ pulses in the same cycle in IDLE at 00:05 -> RUN, value 0005 unchanged. clear and start in the same cycle -> IDLE, 0000.
